// File: rtl/mlp_layer_sequencer.sv
`timescale 1ns/1ps
// mlp_layer_sequencer
// Sequences one fully-connected binary MLP layer. For every output neuron it
// clears the accumulator, streams all input words through the XNOR/popcount
// datapath, waits out the datapath latency and then commits the thresholded
// output bit.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   start              layer start request, sampled only in IDLE
//   num_neurons        neuron count minus 1, latched at start
//   num_words          words per neuron minus 1, latched at start
//   mem_ready          memories accept a read this cycle
//   busy, done         layer in progress / one-cycle completion pulse
//   rd_en, in_addr,
//   wgt_addr           memory read strobe and addresses
//   acc_clr, acc_en    accumulator clear and accumulate strobes
//   out_we, out_addr   output-bit write strobe and neuron index
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; config latched on accept
// CLR    | one-cycle accumulator clear for the current neuron
// STREAM | issue one read per cycle while mem_ready is high
// DRAIN  | let the last read reach the accumulator (LAT cycles)
// WRITE  | commit the output bit of the current neuron
// DONE   | one-cycle completion pulse
module mlp_layer_sequencer #(
    parameter int CNT_W  = 13,
    parameter int ADDR_W = 26,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_neurons,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [CNT_W-1:0]  in_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_we,
    output logic [CNT_W-1:0]  out_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    // DRAIN is left when the down-counter hits zero, so it is loaded with LAT-1.
    localparam logic [2:0] DRAIN_INIT = 3'(LAT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   nn_q;
    logic [CNT_W-1:0]   nw_q;
    logic [CNT_W-1:0]   neuron;
    logic [CNT_W-1:0]   word;
    logic [ADDR_W-1:0]  wgt_q;
    logic [2:0]         drain_cnt;
    logic [LAT-1:0]     acc_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        acc_clr   = 1'b0;
        out_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                busy      = 1'b1;
                acc_clr   = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy  = 1'b1;
                rd_en = mem_ready;
                if (mem_ready && (word == nw_q)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 3'd0) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy   = 1'b1;
                out_we = 1'b1;
                if (neuron == nn_q) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_CLR;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Loop counters and address generator. Counters stop at their terminal
    // value instead of incrementing, so all-ones counts never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nn_q      <= '0;
            nw_q      <= '0;
            neuron    <= '0;
            word      <= '0;
            wgt_q     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nn_q   <= num_neurons;
                        nw_q   <= num_words;
                        neuron <= '0;
                        word   <= '0;
                        wgt_q  <= '0;
                    end
                end
                S_CLR: begin
                    word <= '0;
                end
                S_STREAM: begin
                    if (mem_ready) begin
                        wgt_q <= wgt_q + 1'b1;
                        if (word == nw_q) begin
                            drain_cnt <= DRAIN_INIT;
                        end else begin
                            word <= word + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != 3'd0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (neuron != nn_q) begin
                        neuron <= neuron + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // acc_en is rd_en delayed by exactly LAT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_sr <= '0;
        end else begin
            acc_sr[0] <= rd_en;
            for (int i = 1; i < LAT; i++) begin
                acc_sr[i] <= acc_sr[i-1];
            end
        end
    end

    assign acc_en   = acc_sr[LAT-1];
    assign in_addr  = word;
    assign wgt_addr = wgt_q;
    assign out_addr = neuron;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
`timescale 1ns/1ps
module tb_mlp_layer_sequencer;

    localparam int CNT_W  = 13;
    localparam int ADDR_W = 26;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_neurons;
    logic [CNT_W-1:0]  num_words;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [CNT_W-1:0]  in_addr;
    logic [ADDR_W-1:0] wgt_addr;
    logic              acc_clr;
    logic              acc_en;
    logic              out_we;
    logic [CNT_W-1:0]  out_addr;

    mlp_layer_sequencer #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_neurons(num_neurons), .num_words(num_words), .mem_ready(mem_ready),
        .busy(busy), .done(done), .rd_en(rd_en), .in_addr(in_addr),
        .wgt_addr(wgt_addr), .acc_clr(acc_clr), .acc_en(acc_en),
        .out_we(out_we), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Scoreboard: expected reads (word, weight address), writes, done pulses.
    int exp_in[$];
    int exp_wgt[$];
    int exp_out[$];
    int exp_done = 0;

    // Monitor-side event counters.
    int cnt_rd = 0, cnt_acc = 0, cnt_clr = 0, cnt_we = 0, cnt_done = 0;
    int done_cyc = 0;
    logic [LAT-1:0] rd_hist = '0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops and compares whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (!rst) begin
            rd_hist = '0;
        end else begin
            chk("acc_en_delay", acc_en, rd_hist[LAT-1]);
            rd_hist = {rd_hist[LAT-2:0], rd_en};
            if (acc_en) cnt_acc++;
            if (acc_clr) cnt_clr++;
            if (rd_en) begin
                cnt_rd++;
                if (exp_in.size() == 0) begin
                    chk("unexpected_rd", 1, 0);
                end else begin
                    chk("in_addr", in_addr, exp_in.pop_front());
                    chk("wgt_addr", wgt_addr, exp_wgt.pop_front());
                end
            end
            if (out_we) begin
                cnt_we++;
                if (exp_out.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    chk("out_addr", out_addr, exp_out.pop_front());
                end
            end
            if (done) begin
                cnt_done++;
                done_cyc = cyc;
                if (exp_done == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("busy_at_done", busy, 0);
                    exp_done--;
                end
            end
        end
    end

    int start_cyc;
    int base_rd, base_acc, base_clr, base_we;

    task automatic start_layer(input int nn, input int nw);
        int a = 0;
        for (int n = 0; n <= nn; n++) begin
            for (int w = 0; w <= nw; w++) begin
                exp_in.push_back(w);
                exp_wgt.push_back(a);
                a++;
            end
            exp_out.push_back(n);
        end
        exp_done++;
        base_rd = cnt_rd; base_acc = cnt_acc; base_clr = cnt_clr; base_we = cnt_we;
        @(posedge clk); #1;
        num_neurons = CNT_W'(nn);
        num_words   = CNT_W'(nw);
        start       = 1'b1;
        start_cyc   = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_layer(input int nn, input int nw, input int budget);
        int d0 = cnt_done;
        int t  = 0;
        while (cnt_done == d0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (cnt_done == d0) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        chk("busy_idle", busy, 0);
        chk("rd_left", exp_in.size(), 0);
        chk("we_left", exp_out.size(), 0);
        chk("reads", cnt_rd - base_rd, (nn + 1) * (nw + 1));
        chk("acc_ens", cnt_acc - base_acc, (nn + 1) * (nw + 1));
        chk("acc_clrs", cnt_clr - base_clr, nn + 1);
        chk("out_wes", cnt_we - base_we, nn + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b0; start = 1'b0; mem_ready = 1'b1;
        num_neurons = '0; num_words = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wgt_addr", wgt_addr, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_out_we", out_we, 0);
        rst = 1'b1;

        // Minimal layer: one neuron, one word; done six cycles after start.
        start_layer(0, 0);
        finish_layer(0, 0, 50);
        chk("done_latency", done_cyc - start_cyc, 6);

        // Three neurons of four words.
        start_layer(2, 3);
        finish_layer(2, 3, 100);

        // Two-cycle stall while sitting at word 1.
        start_layer(0, 3);
        t = 0;
        while (in_addr != 1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("stall_reach_word1", in_addr, 1);
        mem_ready = 1'b0;
        #1;
        chk("stall_rd_en_0", rd_en, 0);
        chk("stall_in_addr_0", in_addr, 1);
        @(posedge clk); #1;
        chk("stall_rd_en_1", rd_en, 0);
        chk("stall_in_addr_1", in_addr, 1);
        @(posedge clk); #1;
        chk("stall_in_addr_2", in_addr, 1);
        mem_ready = 1'b1;
        finish_layer(0, 3, 50);

        // Restart and config changes mid-layer are ignored.
        start_layer(1, 1);
        @(posedge clk); #1;
        num_neurons = 13'd5;
        num_words   = 13'd7;
        start       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        finish_layer(1, 1, 100);

        // Reset during STREAM of neuron 1.
        start_layer(2, 3);
        t = 0;
        while (!(out_addr == 1 && rd_en) && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        chk("reach_neuron1_stream", out_addr, 1);
        rst = 1'b0;
        #1;
        chk("arst_rd_en", rd_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_addr", in_addr, 0);
        chk("arst_wgt_addr", wgt_addr, 0);
        chk("arst_out_addr", out_addr, 0);
        chk("arst_acc_en", acc_en, 0);
        exp_in.delete(); exp_wgt.delete(); exp_out.delete();
        exp_done = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_restart_busy", busy, 0);
        start_layer(1, 1);
        finish_layer(1, 1, 100);

        // Maximum neuron count with one word each.
        start_layer(8191, 0);
        finish_layer(8191, 0, 8192 * 8 + 50);

        chk("pending_done", exp_done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
